frogger_ctrl: RTL and testbench

Game sequencer for the 16x16 red/green LED Frogger display. Owns frog position, the six rotating car lanes, collision detection, win/level progression and the sticky game-over flag. Its outputs feed the frame-drawing block directly: frog_x is the LED row, frog_y the column, and car lanes are rows 2, 5, 7, 9, 11 and 12.

---
 rtl/frogger_pkg.sv | 37 +++
 rtl/frogger_lane.sv | 44 ++++
 rtl/frogger_ctrl.sv | 146 ++++++++++++++
 tb/tb_frogger_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared constants and types for the Frogger game sequencer.
// Lane tables are indexed 0..5 for display rows 2, 5, 7, 9, 11, 12.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int NUM_LANES = 6;

  localparam logic [3:0] START_X    = 4'd0;
  localparam logic [3:0] START_Y    = 4'd8;
  localparam logic [3:0] GOAL_ROW   = 4'd15;
  localparam logic [3:0] MAX_COL    = 4'd15;
  localparam logic [3:0] MAX_SCORE  = 4'd15;
  localparam logic [1:0] MAX_LEVEL  = 2'd3;
  localparam logic [1:0] INIT_LIVES = 2'd3;

  localparam logic [3:0]  LANE_ROW  [NUM_LANES] = '{4'd2, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12};
  localparam logic [15:0] LANE_SEED [NUM_LANES] = '{16'hE19F, 16'hBCF8, 16'h79E9,
                                                   16'hF83B, 16'hC7E3, 16'hE7F0};
  localparam logic [2:0]  LANE_BASE [NUM_LANES] = '{3'd4, 3'd3, 3'd5, 3'd2, 3'd4, 3'd3};
  // 1 rotates toward the MSB, 0 toward the LSB
  localparam logic        LANE_DIR  [NUM_LANES] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Reload value max(1, base - level); higher levels shorten the period.
  function automatic logic [2:0] reload_period(input logic [2:0] base, input logic [1:0] lvl);
    logic [2:0] lvl_w;
    lvl_w = {1'b0, lvl};
    if (base > lvl_w + 3'd1) reload_period = base - lvl_w;
    else                     reload_period = 3'd1;
  endfunction

endpackage

// File: rtl/frogger_lane.sv
// One car lane: a tick-driven period counter and a 16-bit rotator.
// The counter resets to 0, so the first tick after reset rotates the lane.
module frogger_lane
  import frogger_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  level,
  input  logic [15:0] seed,
  input  logic [2:0]  base,
  input  logic        dir,
  output logic [15:0] lane
);

  logic [15:0] lane_q, lane_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    lane_d = lane_q;
    cnt_d  = cnt_q;
    if (tick) begin
      if (cnt_q == 3'd0) begin
        lane_d = dir ? {lane_q[14:0], lane_q[15]} : {lane_q[0], lane_q[15:1]};
        cnt_d  = reload_period(base, level);
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= seed;
      cnt_q  <= 3'd0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/frogger_ctrl.sv
// Frogger game sequencer: frog movement, six car lanes, collision, win and game-over.
// Optional feature macro FROGGER_CTRL_LIVES_EN enables a three-life respawn scheme.
module frogger_ctrl
  import frogger_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [3:0]  frog_x,
  output logic [3:0]  frog_y,
  output logic [15:0] car2,
  output logic [15:0] car5,
  output logic [15:0] car7,
  output logic [15:0] car9,
  output logic [15:0] car11,
  output logic [15:0] car12,
  output logic        gameover,
  output logic [3:0]  score,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output state_e      dbg_state
);

  state_e     state_q, state_d;
  logic [3:0] frog_x_q, frog_x_d;
  logic [3:0] frog_y_q, frog_y_d;
  logic [3:0] score_q, score_d;
  logic [1:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] btn;
  logic       hit;

  logic [15:0] lanes [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    frogger_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .level (level_q),
      .seed  (LANE_SEED[i]),
      .base  (LANE_BASE[i]),
      .dir   (LANE_DIR[i]),
      .lane  (lanes[i])
    );
  end

  // Collision uses only registered frog and lane values.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (frog_x_q == LANE_ROW[i] && lanes[i][frog_y_q]) hit = 1'b1;
    end
  end

  assign btn = {btn_up, btn_down, btn_left, btn_right};

  always_comb begin
    state_d  = state_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    score_d  = score_q;
    level_d  = level_q;
    lives_d  = lives_q;
    case (state_q)
      ST_PLAY: begin
        if (hit) begin
          state_d = ST_HIT;
        end else if (frog_x_q == GOAL_ROW) begin
          state_d  = ST_WIN;
          score_d  = (score_q == MAX_SCORE) ? score_q : score_q + 4'd1;
          level_d  = (level_q == MAX_LEVEL) ? level_q : level_q + 2'd1;
          frog_x_d = START_X;
          frog_y_d = START_Y;
        end else if ($onehot(btn)) begin
          if (btn_up    && frog_x_q != GOAL_ROW) frog_x_d = frog_x_q + 4'd1;
          if (btn_down  && frog_x_q != 4'd0)     frog_x_d = frog_x_q - 4'd1;
          if (btn_left  && frog_y_q != MAX_COL)  frog_y_d = frog_y_q + 4'd1;
          if (btn_right && frog_y_q != 4'd0)     frog_y_d = frog_y_q - 4'd1;
        end
      end
      ST_HIT: begin
`ifdef FROGGER_CTRL_LIVES_EN
        lives_d = lives_q - 2'd1;
        if (lives_q != 2'd1) begin
          state_d  = ST_PLAY;
          frog_x_d = START_X;
          frog_y_d = START_Y;
        end else begin
          state_d = ST_OVER;
        end
`else
        state_d = ST_OVER;
`endif
      end
      ST_WIN:  state_d = ST_PLAY;
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PLAY;
      frog_x_q <= START_X;
      frog_y_q <= START_Y;
      score_q  <= 4'd0;
      level_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      score_q  <= score_d;
      level_q  <= level_d;
    end
  end

`ifdef FROGGER_CTRL_LIVES_EN
  always_ff @(posedge clk) begin
    if (reset) lives_q <= INIT_LIVES;
    else       lives_q <= lives_d;
  end
  assign lives = lives_q;
`else
  assign lives_q = 2'd0;
  assign lives   = 2'd0;
`endif

  assign frog_x    = frog_x_q;
  assign frog_y    = frog_y_q;
  assign score     = score_q;
  assign level     = level_q;
  assign gameover  = (state_q == ST_OVER);
  assign dbg_state = state_q;
  assign car2      = lanes[0];
  assign car5      = lanes[1];
  assign car7      = lanes[2];
  assign car9      = lanes[3];
  assign car11     = lanes[4];
  assign car12     = lanes[5];

endmodule

// File: tb/tb_frogger_ctrl.sv
// Bench for frogger_ctrl: directed scenarios then random play against a game-level model.
// Honours FROGGER_CTRL_LIVES_EN the same way as the design.
module tb_frogger_ctrl;
  import frogger_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, tick, btn_up, btn_down, btn_left, btn_right;
  logic [3:0]  frog_x, frog_y, score;
  logic [15:0] car2, car5, car7, car9, car11, car12;
  logic        gameover;
  logic [1:0]  level, lives;
  state_e      dbg_state;

  always #5 clk = ~clk;

  frogger_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frog_x(frog_x), .frog_y(frog_y),
    .car2(car2), .car5(car5), .car7(car7), .car9(car9), .car11(car11), .car12(car12),
    .gameover(gameover), .score(score), .level(level), .lives(lives),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  localparam int EW = 115;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int m_rows [6] = '{2, 5, 7, 9, 11, 12};
  int m_seed [6] = '{'hE19F, 'hBCF8, 'h79E9, 'hF83B, 'hC7E3, 'hE7F0};
  int m_base [6] = '{4, 3, 5, 2, 4, 3};
  bit m_up   [6] = '{1, 0, 1, 0, 1, 0};
  int m_lane [6];
  int m_wait [6];
  int m_fx, m_fy, m_score, m_level, m_lives;
  bit m_over, m_hit, m_win;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_lane[i] = m_seed[i];
      m_wait[i] = 0;
    end
    m_fx = 0; m_fy = 8; m_score = 0; m_level = 0;
`ifdef FROGGER_CTRL_LIVES_EN
    m_lives = 3;
`else
    m_lives = 0;
`endif
    m_over = 0; m_hit = 0; m_win = 0;
  endtask

  task automatic model_step(input bit rst, input bit tk, input bit u, input bit d,
                            input bit l, input bit r);
    bit collide;
    int per;
    if (rst) begin
      model_reset();
      return;
    end
    collide = 0;
    for (int i = 0; i < 6; i++)
      if (m_fx == m_rows[i] && ((m_lane[i] >> m_fy) & 1) == 1) collide = 1;
    if (tk) begin
      for (int i = 0; i < 6; i++) begin
        if (m_wait[i] == 0) begin
          if (m_up[i]) m_lane[i] = ((m_lane[i] << 1) | (m_lane[i] >> 15)) & 'hFFFF;
          else         m_lane[i] = ((m_lane[i] >> 1) | ((m_lane[i] & 1) << 15)) & 'hFFFF;
          per = m_base[i] - m_level;
          m_wait[i] = (per < 1) ? 1 : per;
        end else begin
          m_wait[i] = m_wait[i] - 1;
        end
      end
    end
    if (m_over) begin
    end else if (m_hit) begin
      m_hit = 0;
`ifdef FROGGER_CTRL_LIVES_EN
      m_lives = m_lives - 1;
      if (m_lives > 0) begin m_fx = 0; m_fy = 8; end
      else m_over = 1;
`else
      m_over = 1;
`endif
    end else if (m_win) begin
      m_win = 0;
    end else if (collide) begin
      m_hit = 1;
    end else if (m_fx == 15) begin
      m_win = 1;
      m_score = (m_score < 15) ? m_score + 1 : 15;
      m_level = (m_level < 3) ? m_level + 1 : 3;
      m_fx = 0; m_fy = 8;
    end else if (int'(u) + int'(d) + int'(l) + int'(r) == 1) begin
      if (u && m_fx < 15) m_fx++;
      if (d && m_fx > 0)  m_fx--;
      if (l && m_fy < 15) m_fy++;
      if (r && m_fy > 0)  m_fy--;
    end
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [1:0] st;
    st = m_over ? 2'd3 : m_hit ? 2'd1 : m_win ? 2'd2 : 2'd0;
    return {st, 4'(m_fx), 4'(m_fy), 1'(m_over), 4'(m_score), 2'(m_level), 2'(m_lives),
            16'(m_lane[0]), 16'(m_lane[1]), 16'(m_lane[2]),
            16'(m_lane[3]), 16'(m_lane[4]), 16'(m_lane[5])};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit tk, input bit u, input bit d,
                      input bit l, input bit r);
    logic [EW-1:0] e;
    reset = rst; tick = tk;
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    model_step(rst, tk, u, d, l, r);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state",    dbg_state, e[114:113]);
    check("frog_x",   frog_x,    e[112:109]);
    check("frog_y",   frog_y,    e[108:105]);
    check("gameover", gameover,  e[104]);
    check("score",    score,     e[103:100]);
    check("level",    level,     e[99:98]);
    check("lives",    lives,     e[97:96]);
    check("car2",     car2,      e[95:80]);
    check("car5",     car5,      e[79:64]);
    check("car7",     car7,      e[63:48]);
    check("car9",     car9,      e[47:32]);
    check("car11",    car11,     e[31:16]);
    check("car12",    car12,     e[15:0]);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sel;
    reset = 1; tick = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    model_reset();

    // reset values
    step(1, 0, 0, 0, 0, 0);
    check("rst_frog_x", frog_x, 0);
    check("rst_frog_y", frog_y, 8);
    check("rst_car2", car2, 16'hE19F);
    check("rst_score", score, 0);
    check("rst_gameover", gameover, 0);

    // two ups land on an occupied cell of row 2, column 8
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("up2_row", frog_x, 2);
    idle();
    check("hit_not_over_yet", gameover, 0);
    idle();
    check("hit_over", gameover, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("over_frozen_x", frog_x, 2);
    check("over_frozen_y", frog_y, 8);
    step(0, 1, 0, 0, 0, 0);
    check("over_car2_rot", car2, 16'hC33F);
    idle();
    check("over_sticky", gameover, 1);

    // column clamp at 0, row clamp at 0, and simultaneous buttons
    step(1, 0, 0, 0, 0, 0);
    repeat (9) step(0, 0, 0, 0, 0, 1);
    check("clamp_right", frog_y, 0);
    step(0, 0, 0, 1, 0, 0);
    check("clamp_down", frog_x, 0);
    step(0, 0, 1, 0, 1, 0);
    check("dual_btn_x", frog_x, 0);
    check("dual_btn_y", frog_y, 0);

    // lane rotation from reset
    step(1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    check("car2_4ticks", car2, 16'hC33F);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    check("car9_6ticks", car9, 16'hFE0E);

    // crossing via column 9 then column 11, lanes frozen
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (10) step(0, 0, 1, 0, 0, 0);
    repeat (2)  step(0, 0, 0, 0, 1, 0);
    repeat (5)  step(0, 0, 1, 0, 0, 0);
    check("goal_row", frog_x, 15);
    idle();
    idle();
    check("win_score", score, 1);
    check("win_level", level, 1);
    check("win_frog_x", frog_x, 0);
    check("win_frog_y", frog_y, 8);
    check("win_gameover", gameover, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    check("car9_lvl1", car9, 16'hFE0E);

`ifdef FROGGER_CTRL_LIVES_EN
    step(1, 0, 0, 0, 0, 0);
    check("lives_rst", lives, 3);
    for (int h = 0; h < 3; h++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      idle();
      idle();
      check("lives_after_hit", lives, 2 - h);
      check("over_after_hit", gameover, (h == 2) ? 1 : 0);
    end
    step(1, 0, 0, 0, 0, 0);
    check("lives_rst_again", lives, 3);
`endif

    // random play
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit rst, tk, u, d, l, r;
      rst = ($urandom_range(0, 149) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      u = 0; d = 0; l = 0; r = 0;
      sel = $urandom_range(0, 99);
      if (sel < 35)      u = 1;
      else if (sel < 45) d = 1;
      else if (sel < 55) l = 1;
      else if (sel < 65) r = 1;
      else if (sel < 75) begin
        u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1)); r = 1;
      end
      step(rst, tk, u, d, l, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
